// File: rtl/mem_load_unit_pkg.sv
// Shared encodings for the load unit: access-size codes, FSM state codes and the
// captured-request record, plus the alignment/legality rule used at acceptance.
package mem_load_unit_pkg;

  localparam logic [7:0] MEM_LEN_B = 8'd1;
  localparam logic [7:0] MEM_LEN_H = 8'd2;
  localparam logic [7:0] MEM_LEN_W = 8'd4;

  localparam logic [1:0] LD_IDLE  = 2'd0;
  localparam logic [1:0] LD_WAIT  = 2'd1;
  localparam logic [1:0] LD_DRAIN = 2'd2;

  typedef struct packed {
    logic [1:0] off;
    logic [7:0] len;
    logic       isSigned;
  } ld_req_t;

  // Unknown size codes are treated like a misaligned access so software sees AdEL.
  function automatic logic isBadLoad(input logic [1:0] addrLo, input logic [7:0] len);
    case (len)
      MEM_LEN_W: isBadLoad = (addrLo != 2'b00);
      MEM_LEN_H: isBadLoad = addrLo[0];
      MEM_LEN_B: isBadLoad = 1'b0;
      default:   isBadLoad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// Word-read channel between the load unit (master) and data memory (slave).
interface mem_load_unit_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_rvalid, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_rvalid, output mem_rdata);

endinterface

// File: rtl/mem_load_unit_extract.sv
// Combinational lane select and extension of a returned memory word; the read-side
// mirror of the store lane replication.
module mem_load_unit_extract
  import mem_load_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [7:0]  i_len,
  input  logic        i_signed,
  output logic [31:0] o_result
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];

  always_comb begin
    o_result = i_rdata;
    case (i_len)
      MEM_LEN_H: o_result = {{16{i_signed & w_half[15]}}, w_half};
      MEM_LEN_B: o_result = {{24{i_signed & w_byte[7]}}, w_byte};
      default:   o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// M-stage load unit: checks alignment, issues a word read, waits for the response with
// a timeout, and hands the extended result to W. A flushed load still drains its response.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_addr,
  input  logic [7:0]             ld_len,
  input  logic                   ld_signed,
  input  logic                   flush,
  output logic                   ld_ready,
  output logic                   stall,
  mem_load_unit_if.master        mem,
  output logic                   wb_valid,
  output logic [31:0]            wb_data,
  output logic                   exc_adel,
  output logic                   exc_bus
);

  localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  logic [1:0]       r_state;
  ld_req_t          r_req;
  logic [CNT_W-1:0] r_waitCnt;
  logic             r_memReq;
  logic [31:0]      r_memAddr;

  logic [31:0]      w_extData;
  logic             w_timeout;

  assign ld_ready     = (r_state == LD_IDLE);
  assign stall        = !ld_ready || (ld_valid && !flush);
  assign w_timeout    = !mem.mem_rvalid && (r_waitCnt == LAST_CNT);
  assign mem.mem_req  = r_memReq;
  assign mem.mem_addr = r_memAddr;

  mem_load_unit_extract u_extract (
    .i_rdata  (mem.mem_rdata),
    .i_off    (r_req.off),
    .i_len    (r_req.len),
    .i_signed (r_req.isSigned),
    .o_result (w_extData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= LD_IDLE;
      r_req     <= '0;
      r_waitCnt <= '0;
      r_memReq  <= 1'b0;
      r_memAddr <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      exc_adel  <= 1'b0;
      exc_bus   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      exc_adel <= 1'b0;
      exc_bus  <= 1'b0;
      case (r_state)
        LD_IDLE: begin
          if (ld_valid && !flush) begin
            if (isBadLoad(ld_addr[1:0], ld_len)) begin
              exc_adel <= 1'b1;
            end else begin
              r_req     <= '{off: ld_addr[1:0], len: ld_len, isSigned: ld_signed};
              r_memAddr <= {ld_addr[31:2], 2'b00};
              r_memReq  <= 1'b1;
              r_waitCnt <= '0;
              r_state   <= LD_WAIT;
            end
          end
        end
        LD_WAIT: begin
          // A response in the same cycle as a flush is consumed but never written back.
          if (mem.mem_rvalid) begin
            r_memReq <= 1'b0;
            r_state  <= LD_IDLE;
            if (!flush) begin
              wb_valid <= 1'b1;
              wb_data  <= w_extData;
            end
          end else if (w_timeout) begin
            r_memReq <= 1'b0;
            r_state  <= LD_IDLE;
            exc_bus  <= !flush;
          end else if (flush) begin
            r_waitCnt <= '0;
            r_state   <= LD_DRAIN;
          end else begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end
        LD_DRAIN: begin
          if (mem.mem_rvalid || w_timeout) begin
            r_memReq <= 1'b0;
            r_state  <= LD_IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end
        default: begin
          r_memReq <= 1'b0;
          r_state  <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed plus randomized load transactions against a value-level reference of the
// load unit (alignment rule, lane extraction by arithmetic, fixed-cycle timing).
module tb_mem_load_unit;
  import mem_load_unit_pkg::*;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [7:0]  ld_len;
  logic        ld_signed;
  logic        flush;
  logic        ld_ready;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        exc_adel;
  logic        exc_bus;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] modelWb     = 32'h0;

  mem_load_unit_if mif ();

  mem_load_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_len    (ld_len),
    .ld_signed (ld_signed),
    .flush     (flush),
    .ld_ready  (ld_ready),
    .stall     (stall),
    .mem       (mif),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .exc_adel  (exc_adel),
    .exc_bus   (exc_bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  function automatic logic refBad(input logic [31:0] addr, input logic [7:0] len);
    if (len == MEM_LEN_W) return (addr % 32'd4) != 0;
    if (len == MEM_LEN_H) return (addr % 32'd2) != 0;
    if (len == MEM_LEN_B) return 1'b0;
    return 1'b1;
  endfunction

  // Result computed by shifting the word down to the addressed lane and wrapping
  // negative values into 32 bits, rather than by bit slicing.
  function automatic logic [31:0] refResult(input logic [31:0] addr, input logic [7:0] len,
                                            input logic sgn, input logic [31:0] word);
    logic [31:0] v;
    if (len == MEM_LEN_H) begin
      v = (word >> (((addr % 32'd4) / 32'd2) * 32'd16)) % 32'd65536;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
      return v;
    end
    if (len == MEM_LEN_B) begin
      v = (word >> ((addr % 32'd4) * 32'd8)) % 32'd256;
      if (sgn && v >= 32'd128) v = v - 32'd256;
      return v;
    end
    return word;
  endfunction

  // One load: present at cycle T, respond at T+k (k > MAX_WAIT means never),
  // optionally flush at T+flushAt (1..k, 0 = no flush).
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic sgn,
                               input int k, input logic [31:0] word, input int flushAt);
    logic        bad;
    logic        timedOut;
    logic [31:0] expData;
    int          limit;
    bad      = refBad(addr, len);
    expData  = refResult(addr, len, sgn, word);
    timedOut = (k > MAX_WAIT) && (flushAt == 0);
    limit    = (k > MAX_WAIT) ? MAX_WAIT : k;

    ld_valid  = 1'b1;
    ld_addr   = addr;
    ld_len    = len;
    ld_signed = sgn;
    flush     = 1'b0;
    @(negedge clk);
    checkFlag("ready_at_T", ld_ready, 1'b1);
    checkFlag("stall_at_T", stall, 1'b1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_addr  = $urandom;

    if (bad) begin
      @(negedge clk);
      checkFlag("adel_raised", exc_adel, 1'b1);
      checkFlag("adel_no_req", mif.mem_req, 1'b0);
      checkFlag("adel_ready", ld_ready, 1'b1);
      checkFlag("adel_no_wb", wb_valid, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      checkFlag("adel_pulse_end", exc_adel, 1'b0);
      checkFlag("adel_no_req_later", mif.mem_req, 1'b0);
      @(posedge clk); #1;
      return;
    end

    for (int i = 1; i <= limit; i++) begin
      mif.mem_rvalid = (i == k);
      mif.mem_rdata  = (i == k) ? word : $urandom;
      flush          = (i == flushAt);
      @(negedge clk);
      checkFlag("wait_req", mif.mem_req, 1'b1);
      checkOutput("wait_addr", mif.mem_addr, addr & 32'hFFFF_FFFC);
      checkFlag("wait_stall", stall, 1'b1);
      checkFlag("wait_not_ready", ld_ready, 1'b0);
      checkFlag("wait_no_wb", wb_valid, 1'b0);
      @(posedge clk); #1;
    end
    mif.mem_rvalid = 1'b0;
    flush          = 1'b0;

    @(negedge clk);
    if (flushAt == 0 && !timedOut) modelWb = expData;
    checkFlag("done_wb_valid", wb_valid, (flushAt == 0) && !timedOut);
    checkOutput("done_wb_data", wb_data, modelWb);
    checkFlag("done_exc_bus", exc_bus, timedOut);
    checkFlag("done_exc_adel", exc_adel, 1'b0);
    checkFlag("done_req_low", mif.mem_req, 1'b0);
    checkFlag("done_ready", ld_ready, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checkFlag("pulse_end_wb", wb_valid, 1'b0);
    checkFlag("pulse_end_bus", exc_bus, 1'b0);
    checkOutput("wb_data_hold", wb_data, modelWb);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0]  rLen;
    logic [31:0] rAddr;
    int          rK;
    int          rFlush;

    reset          = 1'b1;
    ld_valid       = 1'b0;
    ld_addr        = '0;
    ld_len         = MEM_LEN_W;
    ld_signed      = 1'b0;
    flush          = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkFlag("reset_ready", ld_ready, 1'b1);
    checkFlag("reset_stall", stall, 1'b0);
    checkFlag("reset_req", mif.mem_req, 1'b0);
    checkOutput("reset_addr", mif.mem_addr, 32'h0);
    checkOutput("reset_wb_data", wb_data, 32'h0);
    checkFlag("reset_exc", exc_adel | exc_bus | wb_valid, 1'b0);
    @(posedge clk); #1;

    applyStimulus(32'h1003, MEM_LEN_B, 1'b0, 1, 32'h80FF1234, 0);
    checkOutput("lbu_spec", modelWb, 32'h00000080);
    applyStimulus(32'h1003, MEM_LEN_B, 1'b1, 1, 32'h80FF1234, 0);
    checkOutput("lb_spec", wb_data, 32'hFFFFFF80);
    applyStimulus(32'h1002, MEM_LEN_H, 1'b1, 1, 32'h80001234, 0);
    checkOutput("lh_spec", wb_data, 32'hFFFF8000);
    applyStimulus(32'h1000, MEM_LEN_H, 1'b0, 1, 32'h80001234, 0);
    checkOutput("lhu_spec", wb_data, 32'h00001234);
    applyStimulus(32'h1002, MEM_LEN_W, 1'b0, 1, 32'h0, 0);
    applyStimulus(32'h1001, MEM_LEN_H, 1'b1, 1, 32'h0, 0);
    applyStimulus(32'h1000, 8'd3, 1'b0, 1, 32'h0, 0);
    applyStimulus(32'h2000, MEM_LEN_W, 1'b0, 5, 32'hDEADBEEF, 0);
    checkOutput("lw_spec", wb_data, 32'hDEADBEEF);
    applyStimulus(32'h2004, MEM_LEN_W, 1'b0, MAX_WAIT + 1, 32'h0, 0);
    applyStimulus(32'h2008, MEM_LEN_W, 1'b0, MAX_WAIT, 32'h12345678, 0);
    applyStimulus(32'h3000, MEM_LEN_W, 1'b0, 5, 32'hCAFEF00D, 2);
    applyStimulus(32'h3004, MEM_LEN_B, 1'b1, 3, 32'hFFFFFFFF, 3);

    // A flushed request in IDLE must be dropped without stalling.
    ld_valid = 1'b1;
    ld_addr  = 32'h4000;
    ld_len   = MEM_LEN_W;
    flush    = 1'b1;
    @(negedge clk);
    checkFlag("flush_idle_stall", stall, 1'b0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    checkFlag("flush_idle_req", mif.mem_req, 1'b0);
    checkFlag("flush_idle_exc", exc_adel, 1'b0);
    checkFlag("flush_idle_ready", ld_ready, 1'b1);
    @(posedge clk); #1;

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: rLen = MEM_LEN_B;
        3, 4:    rLen = MEM_LEN_H;
        7:       rLen = 8'($urandom_range(5, 255));
        default: rLen = MEM_LEN_W;
      endcase
      rAddr  = $urandom;
      if ($urandom_range(0, 1) == 1) rAddr = rAddr & 32'hFFFF_FFFE;
      rK     = $urandom_range(1, 8);
      rFlush = ($urandom_range(0, 4) == 0) ? $urandom_range(1, rK) : 0;
      applyStimulus(rAddr, rLen, 1'($urandom_range(0, 1)), rK, $urandom, rFlush);
    end

    // Reset mid-WAIT, then a stale response arriving while idle.
    ld_valid = 1'b1;
    ld_addr  = 32'h5000;
    ld_len   = MEM_LEN_W;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    @(negedge clk);
    checkFlag("pre_reset_req", mif.mem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset          = 1'b0;
    modelWb        = 32'h0;
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata  = 32'hA5A5A5A5;
    @(negedge clk);
    checkFlag("mid_reset_req", mif.mem_req, 1'b0);
    checkOutput("mid_reset_addr", mif.mem_addr, 32'h0);
    checkOutput("mid_reset_wb_data", wb_data, 32'h0);
    checkFlag("mid_reset_ready", ld_ready, 1'b1);
    checkFlag("mid_reset_stall", stall, 1'b0);
    @(posedge clk); #1;
    mif.mem_rvalid = 1'b0;
    @(negedge clk);
    checkFlag("stale_no_wb", wb_valid, 1'b0);
    checkOutput("stale_wb_data", wb_data, modelWb);
    checkFlag("stale_no_req", mif.mem_req, 1'b0);
    checkFlag("stale_no_exc", exc_adel | exc_bus, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
